// File: rtl/glyph_ram_writer.sv
// Burst writer: loads LINES consecutive slots from a valid/ready stream into an internal RAM
// with a combinational read port. Optional GLYPH_RAM_ERR_EN adds a sticky out-of-range flag (err).
module glyph_ram_writer #(
   parameter int unsigned DATA_WIDTH       = 8,
   parameter int unsigned MEM_SLOT         = 4096,
   parameter int unsigned SLOT_COUNT_WIDTH = 12,
   parameter int unsigned LINES            = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [SLOT_COUNT_WIDTH-1:0] base_addr,
   input  logic                        in_valid,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        in_ready,
   output logic                        busy,
   output logic                        done,
`ifdef GLYPH_RAM_ERR_EN
   output logic                        err,
`endif
   input  logic [SLOT_COUNT_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0]       r_data
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t                      state_q;
   logic [SLOT_COUNT_WIDTH-1:0] base_q;
   logic [7:0]                  count_q;
   logic [7:0]                  count_d;
   logic                        in_ready_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        err_q;

   logic [SLOT_COUNT_WIDTH-1:0] wr_addr;
   logic                        wr_in_range;
   logic                        beat_acc;
   logic                        last_beat;
   logic                        we;

   logic [DATA_WIDTH-1:0]       mem_q [MEM_SLOT];

   // Address wraps naturally through the SLOT_COUNT_WIDTH-bit sum.
   assign wr_addr     = base_q + SLOT_COUNT_WIDTH'(count_q);
   assign wr_in_range = 32'(wr_addr) < MEM_SLOT;
   assign beat_acc    = in_ready_q & in_valid;
   assign last_beat   = count_q == 8'(LINES - 1);
   assign we          = beat_acc & wr_in_range;
   assign count_d     = count_q + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  base_q     <= base_addr;
                  count_q    <= '0;
                  err_q      <= 1'b0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= WRITE;
               end
            end
            WRITE: begin
               if (beat_acc) begin
                  count_q <= count_d;
                  if (!wr_in_range) err_q <= 1'b1;
                  if (last_beat) begin
                     in_ready_q <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   // RAM has no reset so reset mid-burst keeps already written slots.
   always_ff @(posedge clk) begin
      if (we) mem_q[wr_addr] <= in_data;
   end

   assign r_data   = (32'(r_addr) < MEM_SLOT) ? mem_q[r_addr] : '0;
   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
`ifdef GLYPH_RAM_ERR_EN
   assign err      = err_q;
`endif

endmodule

// File: tb/tb_glyph_ram_writer.sv
// Scoreboard bench for glyph_ram_writer: one full-size instance and one with MEM_SLOT=4000,
// driven by the same stream and checked against an array model of slot contents.
module tb_glyph_ram_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] base_addr;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [11:0] r_addr;
   logic        in_ready_a, busy_a, done_a, in_ready_b, busy_b, done_b;
   logic [7:0]  r_data_a, r_data_b;
`ifdef GLYPH_RAM_ERR_EN
   logic        err_a, err_b;
`endif

   glyph_ram_writer #(.DATA_WIDTH(8), .MEM_SLOT(4096), .SLOT_COUNT_WIDTH(12), .LINES(8)) dut_a (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready_a), .busy(busy_a), .done(done_a),
`ifdef GLYPH_RAM_ERR_EN
      .err(err_a),
`endif
      .r_addr(r_addr), .r_data(r_data_a));

   glyph_ram_writer #(.DATA_WIDTH(8), .MEM_SLOT(4000), .SLOT_COUNT_WIDTH(12), .LINES(8)) dut_b (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready_b), .busy(busy_b), .done(done_b),
`ifdef GLYPH_RAM_ERR_EN
      .err(err_b),
`endif
      .r_addr(r_addr), .r_data(r_data_b));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int          kind;   // 0 = read, 1 = control
      logic [11:0] addr;
      logic [7:0]  ea, eb;
      bit          ca, cb;
      bit          ir, bz, dn, eerr;
   } chk_t;

   chk_t chk_q[$];
   int   done_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: slot contents and whether each slot has been written
   logic [7:0] ma [4096];
   logic [7:0] mb [4096];
   bit         ka [4096];
   bit         kb [4096];
   bit         err_m = 1'b0;

   chk_t c;
   int   e;
   always @(negedge clk) begin
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         if (c.kind == 0) begin
            if (c.ca) begin
               total++;
               if (r_data_a !== c.ea) begin
                  bad++;
                  $display("FAIL read_a addr=%h got=%h exp=%h", c.addr, r_data_a, c.ea);
               end
            end
            if (c.cb) begin
               total++;
               if (r_data_b !== c.eb) begin
                  bad++;
                  $display("FAIL read_b addr=%h got=%h exp=%h", c.addr, r_data_b, c.eb);
               end
            end
         end else begin
            total++;
            if ({in_ready_a, busy_a, done_a, in_ready_b, busy_b, done_b} !==
                {c.ir, c.bz, c.dn, c.ir, c.bz, c.dn}) begin
               bad++;
               $display("FAIL ctrl cyc=%0d got a=%b%b%b b=%b%b%b exp=%b%b%b", cyc,
                        in_ready_a, busy_a, done_a, in_ready_b, busy_b, done_b, c.ir, c.bz, c.dn);
            end
`ifdef GLYPH_RAM_ERR_EN
            total++;
            if (err_a !== 1'b0 || err_b !== c.eerr) begin
               bad++;
               $display("FAIL err cyc=%0d got a=%b b=%b exp a=0 b=%b", cyc, err_a, err_b, c.eerr);
            end
`endif
         end
      end
      if (done_a === 1'b1) begin
         total++;
         if (done_q.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
         end else begin
            e = done_q.pop_front();
            if (e != cyc) begin
               bad++;
               $display("FAIL done_cycle got=%0d exp=%0d", cyc, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_ctrl(input bit ir, input bit bz, input bit dn);
      chk_t r;
      r = '{kind: 1, addr: '0, ea: '0, eb: '0, ca: 1'b0, cb: 1'b0,
            ir: ir, bz: bz, dn: dn, eerr: err_m};
      chk_q.push_back(r);
   endtask

   task automatic exp_read(input logic [11:0] a);
      chk_t r;
      r_addr = a;
      r = '{kind: 0, addr: a, ea: ma[a], eb: mb[a], ca: ka[a], cb: kb[a],
            ir: 1'b0, bz: 1'b0, dn: 1'b0, eerr: 1'b0};
      chk_q.push_back(r);
   endtask

   task automatic model_write(input logic [11:0] a, input logic [7:0] d);
      ma[a] = d;
      ka[a] = 1'b1;
      if (a < 12'd4000) begin
         mb[a] = d;
         kb[a] = 1'b1;
      end else begin
         err_m = 1'b1;
      end
   endtask

   // stall < 0: one idle cycle before every beat; otherwise percent chance of idle cycles
   task automatic burst(input logic [11:0] base, input logic [7:0] d [8], input int stall,
                        input int rst_after, input bit ign, input bit rw);
      logic [11:0] a;
      int          k;
      start     = 1'b1;
      base_addr = base;
      tick();
      start = 1'b0;
      err_m = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rst_after > 0 && i == rst_after) begin
            in_valid = 1'b0;
            rst      = 1'b1;
            err_m    = 1'b0;
            #1;
            exp_ctrl(1'b0, 1'b0, 1'b0);
            tick();
            rst = 1'b0;
            return;
         end
         if (ign && i == 2) begin
            start     = 1'b1;
            base_addr = base ^ 12'h555;
            in_valid  = 1'b0;
            exp_ctrl(1'b1, 1'b1, 1'b0);
            tick();
            start = 1'b0;
         end
         k = 0;
         while ((stall < 0 && k < 1) || (stall > 0 && k < 4 && $urandom_range(99) < stall)) begin
            in_valid = 1'b0;
            exp_ctrl(1'b1, 1'b1, 1'b0);
            tick();
            k++;
         end
         a        = base + 12'(i);
         in_valid = 1'b1;
         in_data  = d[i];
         exp_ctrl(1'b1, 1'b1, 1'b0);
         if (rw && i == 0) exp_read(a);
         tick();
         model_write(a, d[i]);
         if (i == 7) done_q.push_back(cyc);
         if (rw && i == 0) exp_read(a);
      end
      in_valid = 1'b0;
      exp_ctrl(1'b0, 1'b1, 1'b1);
      tick();
      exp_ctrl(1'b0, 1'b0, 1'b0);
   endtask

   task automatic read_range(input logic [11:0] a0, input int n);
      for (int i = 0; i < n; i++) begin
         exp_read(a0 + 12'(i));
         tick();
      end
   endtask

   logic [7:0]  d [8];
   logic [11:0] rb;

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_data = '0; r_addr = '0;
      tick();
      exp_ctrl(1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      exp_ctrl(1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) d[i] = 8'h30 + 8'(i);
      burst(12'h018, d, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) d[i] = 8'hA0 + 8'(i);
      burst(12'h010, d, 0, 0, 1'b0, 1'b0);
      read_range(12'h010, 9);

      for (int i = 0; i < 8; i++) d[i] = 8'hB0 + 8'(i);
      burst(12'h020, d, -1, 0, 1'b1, 1'b0);
      read_range(12'h020, 8);
      read_range(12'h575, 1);

      for (int i = 0; i < 8; i++) d[i] = 8'h11 + 8'(i);
      burst(12'hFFC, d, 0, 0, 1'b0, 1'b0);
      read_range(12'hFFC, 8);

      for (int i = 0; i < 8; i++) d[i] = 8'h01 + 8'(i);
      burst(12'd3996, d, 0, 0, 1'b0, 1'b0);
      read_range(12'd3996, 8);
      read_range(12'h000, 4);

      for (int i = 0; i < 8; i++) d[i] = 8'hC0 + 8'(i);
      burst(12'h100, d, 0, 3, 1'b0, 1'b0);
      read_range(12'h100, 8);
      for (int i = 0; i < 8; i++) d[i] = 8'hD0 + 8'(i);
      burst(12'h100, d, 0, 0, 1'b0, 1'b1);
      read_range(12'h100, 8);

      for (int n = 0; n < 25; n++) begin
         rb = 12'($urandom);
         for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
         burst(rb, d, 30, 0, 1'b0, 1'b0);
         for (int j = 0; j < 4; j++) begin
            exp_read(rb + 12'($urandom_range(7)));
            tick();
         end
      end

      tick();
      tick();
      total++;
      if (done_q.size() != 0) begin
         bad++;
         $display("FAIL done_missing got=0 exp=%0d pending", done_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/glyph_ram_writer.md
# glyph_ram_writer

Burst writer that loads fixed-length groups of consecutive memory slots (one glyph of LINES rows) into an internal RAM. It receives data over a valid/ready stream and exposes a combinational read port matching the existing ROM read interface, so display-side readers can fetch the stored rows unchanged. It sits between the host/UART byte path and the character renderer, so glyph tables can be rewritten at run time instead of being fixed at elaboration.

## Interface
- DATA_WIDTH, 8: width of one memory slot and of in_data / r_data.
- MEM_SLOT, 4096: number of RAM slots.
- SLOT_COUNT_WIDTH, 12: address width; 2^SLOT_COUNT_WIDTH >= MEM_SLOT.
- LINES, 8: beats per burst, 1..255.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a burst; sampled only in IDLE.
- base_addr  in  SLOT_COUNT_WIDTH  first slot of the burst; latched with start.
- in_valid  in  1  producer has a beat on in_data.
- in_data  in  DATA_WIDTH  beat payload.
- in_ready  out  1  writer accepts a beat this cycle.
- busy  out  1  burst in progress (WRITE or DONE).
- done  out  1  one-cycle pulse after the last beat is written.
- r_addr  in  SLOT_COUNT_WIDTH  read address.
- r_data  out  DATA_WIDTH  combinational mem[r_addr].

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: in_ready=0, busy=0. On start=1, latch base_addr, clear beat counter, go to WRITE.
- WRITE: in_ready=1, busy=1. On in_valid&in_ready, write in_data to slot (base + count) and increment count. When the LINES-th beat is accepted, go to DONE.
- DONE: in_ready=0, busy=1, done=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is modulo 2^SLOT_COUNT_WIDTH, so a burst wraps from the top address to 0.
- A beat whose computed address is >= MEM_SLOT is consumed and counted, but no slot is written.
- start is ignored while busy=1. start asserted in the same cycle DONE exits is ignored; it must be held or re-asserted in IDLE.
- in_valid low during WRITE stalls the burst for any number of cycles. There is no timeout.
- Reset returns the block to IDLE with in_ready=0, busy=0, done=0 and counter=0. RAM contents are not cleared. Slots already written by a burst interrupted by reset keep their new values.
- Reads are independent of writes. r_data is unaffected by the FSM except through written slots.

## Timing
- start sampled at edge N: in_ready=1 from cycle N+1.
- Beat accepted at edge M: the slot holds the new value after edge M. A read of that address during cycle M+1 returns the new data. Same-cycle read returns the old data.
- Back-to-back beats: one per cycle. Minimum burst is 1 (start) + LINES (beats) + 1 (done) = LINES+2 cycles.
- Earliest next start is accepted one cycle after done.
- After reset release, the first start is honoured on the first edge.

## Configuration
- GLYPH_RAM_ERR_EN defined: adds output err (1 bit, reset 0).
  - err becomes sticky 1 on any accepted beat whose address is >= MEM_SLOT.
  - err is cleared when a new start is accepted.
  - If a drop occurs in the same cycle a start is accepted, the start clearing takes precedence; this cannot occur in practice.
- GLYPH_RAM_ERR_EN undefined: no err port. Out-of-range beats are silently dropped.

## Test plan
- Basic burst, default params: start with base_addr=0x010, feed 8 consecutive beats 0xA0..0xA7 -> in_ready high for 8 cycles, done pulses once one cycle after the 8th beat; r_addr=0x010..0x017 returns 0xA0..0xA7, and 0x018 is unchanged.
- Stalls: same burst with in_valid low on alternate cycles -> exactly 8 writes, correct data order, done 1 cycle after the last accepted beat, busy high throughout.
- Wrap: base_addr=0xFFC, beats 0x11..0x18 -> slots 0xFFC..0xFFF hold 0x11..0x14 and slots 0x000..0x003 hold 0x15..0x18.
- Out of range: MEM_SLOT=4000, base_addr=3996, beats 0x01..0x08 -> slots 3996..3999 hold 0x01..0x04, nothing else changes, done still pulses. With GLYPH_RAM_ERR_EN, err=1 after the 5th beat and 0 after the next start.
- Ignored start and reset mid-burst:
  - Pulse start while busy -> no effect on base or count.
  - Assert rst after 3 beats -> in_ready, busy and done are 0 immediately; those 3 slots are kept.
  - A new start with base 0x100 then runs a full 8-beat burst normally.
- Read/write same address: read base address during the beat cycle returns old data and returns new data the next cycle.
